blink_rate_sel: RTL and testbench
=================================

BLINK_RATE_SEL -- requirements
Module: blink_rate_sel

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 125000000, giving the input clock frequency in Hz.
REQ-002 The block SHALL have parameter DEB_CYCLES, default 2500000 (20 ms), giving the consecutive stable cycles required to accept a button level change.
REQ-003 The block SHALL have parameter CNT_W, default 27, giving the width of the half-period and debounce counters.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port btn, input, 1 bit: raw push-button, active-high, asynchronous to clk and bouncing.
REQ-007 The block SHALL have port led, output, 1 bit: blink output, registered.
REQ-008 The block SHALL have port rate, output, 2 bits: current rate state, registered.
REQ-009 The block SHALL have port btn_pressed, output, 1 bit: one-cycle pulse per accepted press, registered.

Function
REQ-010 btn SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-011 Debounce: while sync2 differs from the debounced level deb, the debounce counter SHALL increment each cycle; when sync2 equals deb, the counter SHALL clear to 0.
REQ-012 When sync2 differs from deb and the counter equals DEB_CYCLES-1, deb SHALL take sync2 and the counter SHALL clear on that same edge.
REQ-013 A raw btn rise held stable SHALL produce deb=1 on the (DEB_CYCLES+2)th rising edge, counting the first edge that samples btn=1 as edge 1.
REQ-014 A glitch shorter than DEB_CYCLES cycles at sync2 SHALL produce no change in deb and no btn_pressed pulse.
REQ-015 btn_pressed SHALL be 1 for exactly the one cycle following the edge on which deb changes 0->1, and SHALL be 0 otherwise; a deb 1->0 change (release) SHALL produce no pulse.
REQ-016 rate SHALL advance on the same edge that sets btn_pressed, cycling 0 (1 Hz) -> 1 (2 Hz) -> 2 (4 Hz) -> 3 (OFF) -> 0.
REQ-017 The half-period value HALF SHALL be CLK_HZ/2 for rate 0, CLK_HZ/4 for rate 1, and CLK_HZ/8 for rate 2, using integer division at elaboration time; CLK_HZ/2 SHALL fit in CNT_W bits.
REQ-018 When rate is 0..2, the half-period counter SHALL count 0..HALF-1; on the edge where it equals HALF-1, led SHALL invert and the counter SHALL return to 0, giving a toggle every HALF cycles.
REQ-019 When rate is 3 (OFF), led SHALL be 0 and the half-period counter SHALL be held at 0.
REQ-020 On any rate change edge, the half-period counter SHALL clear to 0. led SHALL be cleared to 0 when entering OFF and SHALL keep its value otherwise.
REQ-021 A rate change SHALL take priority over a coincident terminal count: led does not toggle on that edge.
REQ-022 After reset release with btn low, the first led toggle SHALL occur on the CLK_HZ/2-th rising edge.

Reset
REQ-023 While rst_n=0, the following SHALL be 0 regardless of clk: sync1, sync2, deb, the debounce counter, the half-period counter, led, rate, and btn_pressed.
REQ-024 Reset asserted mid-operation (mid-debounce or mid-period) SHALL abort immediately; after release, behaviour SHALL be identical to power-up, with no pending pulse or rate change.

Verification (bench parameters CLK_HZ=16, DEB_CYCLES=4; HALF=8/4/2)
REQ-025 Reset release with btn=0 held SHALL give led=0, rate=0, and btn_pressed=0, with led toggling on edges 8, 16, 24, and so on after release.
REQ-026 A clean btn rise held for 10 cycles SHALL produce a btn_pressed pulse in the cycle after edge 6, rate 0->1 on that edge, and led toggling every 4 cycles afterwards.
REQ-027 A 3-cycle btn pulse, and a bounce pattern 1,0,1,0 followed by a stable 1, SHALL produce exactly zero and exactly one btn_pressed pulse respectively.
REQ-028 Four accepted presses SHALL make rate go 1,2,3,0; in state 3, led SHALL be 0 with no toggles for 20 cycles; on returning to state 0, the first toggle SHALL come 8 cycles after the press edge.
REQ-029 A press accepted on the same edge as a terminal count SHALL leave led unchanged and restart the period from 0.
REQ-030 rst_n pulled low for 1 cycle when the debounce counter equals 2, or when led=1 in rate 2, SHALL force all outputs to 0 asynchronously, and normal operation SHALL restart from REQ-025 conditions.

Source files
------------

// File: rtl/blink_rate_sel.sv
// Push-button rate selector: a debounced press steps the LED blink rate
// through 1 Hz, 2 Hz, 4 Hz and OFF.
module blink_rate_sel #(
  parameter int CLK_HZ     = 125000000,
  parameter int DEB_CYCLES = 2500000,
  parameter int CNT_W      = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic       led,
  output logic [1:0] rate,
  output logic       btn_pressed
);

  localparam logic [1:0]       RATE_1HZ  = 2'd0;
  localparam logic [1:0]       RATE_2HZ  = 2'd1;
  localparam logic [1:0]       RATE_OFF  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF0_END = CNT_W'(CLK_HZ / 2 - 1);
  localparam logic [CNT_W-1:0] HALF1_END = CNT_W'(CLK_HZ / 4 - 1);
  localparam logic [CNT_W-1:0] HALF2_END = CNT_W'(CLK_HZ / 8 - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] hp_cnt_q, hp_cnt_d;
  logic             led_q, led_d;
  logic [1:0]       rate_q, rate_d;
  logic             btn_pressed_q, btn_pressed_d;
  logic             press_s;
  logic [CNT_W-1:0] half_end_s;

  // Synchronizer and debounce filter.
  always_comb begin
    sync1_d   = btn;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d     = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_ONE;
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  // Only an accepted 0->1 transition of the debounced level counts as a press.
  assign press_s = sync2_q & ~deb_q & (deb_cnt_q == DEB_LAST);

  always_comb begin
    case (rate_q)
      RATE_1HZ: half_end_s = HALF0_END;
      RATE_2HZ: half_end_s = HALF1_END;
      default:  half_end_s = HALF2_END;
    endcase
  end

  // Rate stepping and half-period blink generator; a press outranks a terminal count.
  always_comb begin
    btn_pressed_d = press_s;
    rate_d        = rate_q;
    led_d         = led_q;
    hp_cnt_d      = hp_cnt_q;
    if (press_s) begin
      rate_d   = rate_q + 2'd1;
      hp_cnt_d = '0;
      led_d    = (rate_d == RATE_OFF) ? 1'b0 : led_q;
    end else if (rate_q == RATE_OFF) begin
      led_d    = 1'b0;
      hp_cnt_d = '0;
    end else if (hp_cnt_q == half_end_s) begin
      led_d    = ~led_q;
      hp_cnt_d = '0;
    end else begin
      hp_cnt_d = hp_cnt_q + CNT_ONE;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      deb_q         <= 1'b0;
      deb_cnt_q     <= '0;
      hp_cnt_q      <= '0;
      led_q         <= 1'b0;
      rate_q        <= 2'd0;
      btn_pressed_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_q         <= deb_d;
      deb_cnt_q     <= deb_cnt_d;
      hp_cnt_q      <= hp_cnt_d;
      led_q         <= led_d;
      rate_q        <= rate_d;
      btn_pressed_q <= btn_pressed_d;
    end
  end

  assign led         = led_q;
  assign rate        = rate_q;
  assign btn_pressed = btn_pressed_q;

endmodule

// File: tb/tb_blink_rate_sel.sv
// Directed bench for blink_rate_sel with CLK_HZ=16, DEB_CYCLES=4 and a
// sliding-window reference model feeding a scoreboard queue.
module tb_blink_rate_sel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       led;
  logic [1:0] rate;
  logic       btn_pressed;

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt = 0;

  logic [3:0] sb_q[$];

  // Reference model: smp[k] is btn sampled k edges ago.
  logic [5:0] smp;
  logic       deb_m;
  logic [1:0] rate_m;
  int         since_m;
  logic       led_m;

  blink_rate_sel #(.CLK_HZ(16), .DEB_CYCLES(4), .CNT_W(27)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .led(led), .rate(rate), .btn_pressed(btn_pressed)
  );

  always #5 clk = ~clk;

  function automatic int half_of(input logic [1:0] r);
    case (r)
      2'd0:    return 8;
      2'd1:    return 4;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    smp = 6'b0; deb_m = 1'b0; rate_m = 2'd0; since_m = 0; led_m = 1'b0;
  endtask

  // A level is accepted once sync2 has shown it for four edges in a row,
  // i.e. btn samples from 5..2 edges ago all disagree with the debounced level.
  task automatic model_edge(input logic b, output logic [3:0] e);
    logic flip, press;
    smp   = {smp[4:0], b};
    flip  = (smp[5:2] == {4{~deb_m}});
    press = flip && !deb_m;
    if (flip) deb_m = ~deb_m;
    if (press) begin
      rate_m  = rate_m + 2'd1;
      since_m = 0;
      if (rate_m == 2'd3) led_m = 1'b0;
    end else if (rate_m == 2'd3) begin
      led_m = 1'b0; since_m = 0;
    end else begin
      since_m++;
      if (since_m == half_of(rate_m)) begin
        led_m = ~led_m; since_m = 0;
      end
    end
    e = {led_m, rate_m, press};
  endtask

  task automatic compare(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic b);
    logic [3:0] e;
    @(negedge clk);
    btn = b;
    model_edge(b, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (btn_pressed === 1'b1) pulse_cnt++;
    compare("cycle", {led, rate, btn_pressed}, sb_q.pop_front());
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) cyc(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare("async_rst", {led, rate, btn_pressed}, 4'h0);
    @(posedge clk);
    #1;
    compare("in_rst", {led, rate, btn_pressed}, 4'h0);
    btn   = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_pulses(input string tag, input int exp);
    vectors++;
    assert (pulse_cnt == exp) else begin
      miscompares++;
      $error("FAIL %s got=%0d exp=%0d", tag, pulse_cnt, exp);
    end
  endtask

  initial begin
    model_reset();
    // Idle blinking at 1 Hz: toggles on edges 8, 16, 24.
    do_reset();
    hold(1'b0, 26);
    // Clean press: pulse after edge 6, then 4-cycle toggles.
    hold(1'b1, 10);
    hold(1'b0, 10);
    // Short pulse must be rejected.
    pulse_cnt = 0;
    hold(1'b1, 3);
    hold(1'b0, 10);
    check_pulses("short_pulse", 0);
    // Bounce then stable high yields exactly one press.
    pulse_cnt = 0;
    cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b0);
    hold(1'b1, 8);
    hold(1'b0, 10);
    check_pulses("bounce", 1);

    // Full rate cycle with OFF dwell and return to 1 Hz.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    hold(1'b0, 20);
    hold(1'b1, 8);
    hold(1'b0, 12);

    // Press accepted on the terminal-count edge (edge 8).
    do_reset();
    hold(1'b0, 2);
    hold(1'b1, 8);
    hold(1'b0, 12);

    // Reset mid-debounce (counter at 2) then restart cleanly.
    do_reset();
    hold(1'b1, 4);
    do_reset();
    hold(1'b0, 12);

    // Reset while led=1 in the 4 Hz rate.
    for (int p = 0; p < 2; p++) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    for (int i = 0; i < 10 && !(led_m && rate_m == 2'd2); i++) cyc(1'b0);
    compare("led_high_r2", {led, rate, 1'b0}, 4'b1100);
    do_reset();
    hold(1'b0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
